// File: rtl/mp_calc_sched_pkg.sv
// rtl/mp_calc_sched_pkg.sv - shared widths, opcodes, latencies and FSM encoding for the calculator scheduler
package mp_calc_pkg;

    localparam int W   = 16;
    localparam int OPW = 8;

    localparam logic [OPW-1:0] OP_ADD  = 8'd0;
    localparam logic [OPW-1:0] OP_SUB  = 8'd1;
    localparam logic [OPW-1:0] OP_MUL  = 8'd2;
    localparam logic [OPW-1:0] OP_AND  = 8'd3;
    localparam logic [OPW-1:0] OP_OR   = 8'd4;
    localparam logic [OPW-1:0] OP_XOR  = 8'd5;
    localparam logic [OPW-1:0] OP_DIV  = 8'd6;
    localparam logic [OPW-1:0] OP_MAC  = 8'd7;
    localparam logic [OPW-1:0] OP_SHL  = 8'd8;
    localparam logic [OPW-1:0] OP_SHR  = 8'd9;
    localparam logic [OPW-1:0] OP_MAX  = OP_SHR;

    // Counter width follows the longest latency so no cycle count can overflow it.
    localparam int LAT_OP7_CYC = 94;
    localparam int CNTW        = $clog2(LAT_OP7_CYC + 1);

    typedef logic [CNTW-1:0] cnt_t;

    localparam cnt_t LAT_BASIC = cnt_t'(9);
    localparam cnt_t LAT_OP6   = cnt_t'(43);
    localparam cnt_t LAT_OP7   = cnt_t'(LAT_OP7_CYC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Cycles from the compute pulse until the calculator result may be sampled.
    function automatic cnt_t lat_of(input logic [OPW-1:0] op);
        case (op)
            OP_DIV:  lat_of = LAT_OP6;
            OP_MAC:  lat_of = LAT_OP7;
            default: lat_of = LAT_BASIC;
        endcase
    endfunction

endpackage

// File: rtl/mp_calc_sched_if.sv
// rtl/mp_calc_sched_if.sv - request, response and calculator-side signal bundle for mp_calc_sched
interface mp_calc_sched_if;
    import mp_calc_pkg::*;

    logic           req0_valid;
    logic           req0_ready;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req0_b;
    logic [W-1:0]   req0_c;
    logic [W-1:0]   req0_d;
    logic [OPW-1:0] req0_opcode;

    logic           req1_valid;
    logic           req1_ready;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req1_b;
    logic [W-1:0]   req1_c;
    logic [W-1:0]   req1_d;
    logic [OPW-1:0] req1_opcode;

    logic           resp0_valid;
    logic           resp1_valid;
    logic [W-1:0]   resp_data;
    logic [W-1:0]   resp_im;
    logic           resp_illegal;

    logic [W-1:0]   calc_a;
    logic [W-1:0]   calc_b;
    logic [W-1:0]   calc_c;
    logic [W-1:0]   calc_d;
    logic [OPW-1:0] calc_opcode;
    logic           calc_compute;
    logic [W-1:0]   calc_out;
    logic [W-1:0]   calc_im;

    logic           busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_c, req0_d, req0_opcode,
        input  req1_valid, req1_a, req1_b, req1_c, req1_d, req1_opcode,
        input  calc_out, calc_im,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_data, resp_im, resp_illegal,
        output calc_a, calc_b, calc_c, calc_d, calc_opcode, calc_compute,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_c, req0_d, req0_opcode,
        output req1_valid, req1_a, req1_b, req1_c, req1_d, req1_opcode,
        output calc_out, calc_im,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_data, resp_im, resp_illegal,
        input  calc_a, calc_b, calc_c, calc_d, calc_opcode, calc_compute,
        input  busy
    );

endinterface

// File: rtl/mp_calc_sched_rr_arb2.sv
// rtl/mp_calc_sched_rr_arb2.sv - two-input round-robin grant with last-grant memory
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_q;

    // On contention the requester that did not win last time takes the grant.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    // last_q starts at 1 so requester 0 wins the first contention after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/mp_calc_sched.sv
// rtl/mp_calc_sched.sv - two-requester round-robin scheduler in front of MP_calculator
module mp_calc_sched
    import mp_calc_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mp_calc_sched_if.slave bus
);

    state_t         state_q;
    state_t         state_d;
    logic [1:0]     grant;
    logic           ready0;
    logic           ready1;
    logic           accept;
    logic           sel1;
    logic           illegal_in;
    logic           owner_q;
    logic           illegal_q;
    cnt_t           cnt_q;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [W-1:0]   sel_c;
    logic [W-1:0]   sel_d;
    logic [OPW-1:0] sel_op;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   c_q;
    logic [W-1:0]   d_q;
    logic [OPW-1:0] op_q;
    logic [W-1:0]   data_q;
    logic [W-1:0]   im_q;
    logic           compute;
    logic           busy;
    logic           resp0_valid;
    logic           resp1_valid;
    logic           resp_illegal;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({bus.req1_valid, bus.req0_valid}),
        .update (accept),
        .grant  (grant)
    );

    // Ready is gated by reset so a held valid cannot see ready while reset is asserted.
    assign ready0     = (state_q == ST_IDLE) && grant[0] && reset;
    assign ready1     = (state_q == ST_IDLE) && grant[1] && reset;
    assign accept     = ready0 || ready1;
    assign sel1       = grant[1];
    assign sel_a      = sel1 ? bus.req1_a      : bus.req0_a;
    assign sel_b      = sel1 ? bus.req1_b      : bus.req0_b;
    assign sel_c      = sel1 ? bus.req1_c      : bus.req0_c;
    assign sel_d      = sel1 ? bus.req1_d      : bus.req0_d;
    assign sel_op     = sel1 ? bus.req1_opcode : bus.req0_opcode;
    assign illegal_in = (sel_op > OP_MAX);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state strobes; illegal opcodes skip the calculator entirely.
    always_comb begin
        state_d      = state_q;
        compute      = 1'b0;
        busy         = 1'b1;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        resp_illegal = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_d = illegal_in ? ST_DONE : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                compute = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                resp0_valid  = !owner_q;
                resp1_valid  = owner_q;
                resp_illegal = illegal_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands, owner and illegal flag are captured at accept and held for the whole operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            op_q      <= '0;
            owner_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            a_q       <= sel_a;
            b_q       <= sel_b;
            c_q       <= sel_c;
            d_q       <= sel_d;
            op_q      <= sel_op;
            owner_q   <= sel1;
            illegal_q <= illegal_in;
        end
    end

    // Loaded one short of the latency because WAIT itself spends the cycle in which cnt reaches 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q == ST_LAUNCH) begin
            cnt_q <= lat_of(op_q) - cnt_t'(1);
        end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - cnt_t'(1);
        end
    end

    // Result registers: cleared for an illegal request, captured on the final WAIT cycle, otherwise held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            im_q   <= '0;
        end else if (accept && illegal_in) begin
            data_q <= '0;
            im_q   <= '0;
        end else if ((state_q == ST_WAIT) && (cnt_q == '0)) begin
            data_q <= bus.calc_out;
            im_q   <= bus.calc_im;
        end
    end

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
    assign bus.calc_a       = a_q;
    assign bus.calc_b       = b_q;
    assign bus.calc_c       = c_q;
    assign bus.calc_d       = d_q;
    assign bus.calc_opcode  = op_q;
    assign bus.calc_compute = compute;
    assign bus.resp0_valid  = resp0_valid;
    assign bus.resp1_valid  = resp1_valid;
    assign bus.resp_illegal = resp_illegal;
    assign bus.resp_data    = data_q;
    assign bus.resp_im      = im_q;
    assign bus.busy         = busy;

endmodule

// File: tb/tb_mp_calc_sched.sv
// tb/tb_mp_calc_sched.sv - randomized self-checking bench for mp_calc_sched
module tb_mp_calc_sched;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mp_calc_sched_if bus ();

    mp_calc_sched dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic        r_valid [2];
    logic [15:0] r_a [2];
    logic [15:0] r_b [2];
    logic [15:0] r_c [2];
    logic [15:0] r_d [2];
    logic [7:0]  r_op [2];
    bit          r_scr [2];
    bit          took [2];

    bit          in_reset;
    int          free_at;
    int          m_last;
    bit          job;
    int          j_owner;
    int          j_acc;
    int          j_comp;
    int          j_resp;
    logic [71:0] j_ops;
    logic [31:0] j_res;
    bit          j_ill;

    int          cm_cnt;
    logic [31:0] cm_res;

    function automatic int lat_ref(input logic [7:0] op);
        case (op)
            8'd6:    return 43;
            8'd7:    return 94;
            default: return 9;
        endcase
    endfunction

    // Calculator behaviour: {im, out}.
    function automatic logic [31:0] calc_ref(input logic [7:0] op, input logic [15:0] a, b, c, d);
        logic [15:0] o;
        logic [15:0] m;
        logic [31:0] p;
        o = '0;
        m = '0;
        case (op)
            8'd0: o = a + b;
            8'd1: o = a - b;
            8'd2: begin p = 32'(a) * 32'(b); o = p[15:0]; m = p[31:16]; end
            8'd3: o = a & b;
            8'd4: o = a | b;
            8'd5: o = a ^ b;
            8'd6: begin
                if (b == 16'd0) begin o = 16'hffff; m = a; end
                else begin o = a / b; m = a % b; end
            end
            8'd7: begin p = 32'(a) * 32'(b) + 32'(c) * 32'(d); o = p[15:0]; m = p[31:16]; end
            8'd8: o = a << b[3:0];
            8'd9: o = a >> b[3:0];
            default: begin o = '0; m = '0; end
        endcase
        return {m, o};
    endfunction

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        bus.req0_valid  = r_valid[0];
        bus.req0_a      = r_a[0];
        bus.req0_b      = r_b[0];
        bus.req0_c      = r_c[0];
        bus.req0_d      = r_d[0];
        bus.req0_opcode = r_op[0];
        bus.req1_valid  = r_valid[1];
        bus.req1_a      = r_a[1];
        bus.req1_b      = r_b[1];
        bus.req1_c      = r_c[1];
        bus.req1_d      = r_d[1];
        bus.req1_opcode = r_op[1];
    endtask

    task automatic post(input int n, input logic [15:0] a, b, c, d, input logic [7:0] op, input bit scr);
        r_valid[n] = 1'b1;
        r_a[n]     = a;
        r_b[n]     = b;
        r_c[n]     = c;
        r_d[n]     = d;
        r_op[n]    = op;
        r_scr[n]   = scr;
        drive();
    endtask

    // One clock: check every output mid-cycle against the timing rules, then advance.
    task automatic step();
        int win;
        bit idle;
        @(negedge clk);
        if (bus.calc_compute === 1'b1) begin
            cm_cnt = lat_ref(bus.calc_opcode);
            cm_res = calc_ref(bus.calc_opcode, bus.calc_a, bus.calc_b, bus.calc_c, bus.calc_d);
        end
        idle = !in_reset && (cyc >= free_at);
        win = -1;
        if (r_valid[0] && r_valid[1]) win = (m_last == 1) ? 0 : 1;
        else if (r_valid[0])          win = 0;
        else if (r_valid[1])          win = 1;

        chk("ready0", bus.req0_ready, idle && (win == 0));
        chk("ready1", bus.req1_ready, idle && (win == 1));
        chk("busy", bus.busy, !in_reset && !idle);
        chk("compute", bus.calc_compute, job && (cyc == j_comp));
        chk("resp0_valid", bus.resp0_valid, job && (cyc == j_resp) && (j_owner == 0));
        chk("resp1_valid", bus.resp1_valid, job && (cyc == j_resp) && (j_owner == 1));
        if (job && (cyc > j_acc)) begin
            chk("calc_operands", {bus.calc_a, bus.calc_b, bus.calc_c, bus.calc_d, bus.calc_opcode}, j_ops);
        end
        if (job && (cyc == j_resp)) begin
            chk("resp_data", bus.resp_data, j_res[15:0]);
            chk("resp_im", bus.resp_im, j_res[31:16]);
            chk("resp_illegal", bus.resp_illegal, j_ill);
            job = 0;
        end else begin
            chk("resp_illegal_quiet", bus.resp_illegal, 1'b0);
        end

        if (idle && (win >= 0)) begin
            job     = 1;
            j_owner = win;
            j_acc   = cyc;
            j_ops   = {r_a[win], r_b[win], r_c[win], r_d[win], r_op[win]};
            j_ill   = (r_op[win] > 8'd9);
            if (j_ill) begin
                j_comp = -1;
                j_resp = cyc + 1;
                j_res  = '0;
            end else begin
                j_comp = cyc + 1;
                j_resp = cyc + 2 + lat_ref(r_op[win]);
                j_res  = calc_ref(r_op[win], r_a[win], r_b[win], r_c[win], r_d[win]);
            end
            free_at   = j_resp + 1;
            m_last    = win;
            took[win] = 1;
        end

        @(posedge clk);
        #1;
        cyc++;
        if (cm_cnt >= 0) cm_cnt--;
        bus.calc_out = (cm_cnt == 0) ? cm_res[15:0]  : ~cm_res[15:0];
        bus.calc_im  = (cm_cnt == 0) ? cm_res[31:16] : ~cm_res[31:16];
        for (int n = 0; n < 2; n++) begin
            if (took[n]) begin
                took[n]    = 0;
                r_valid[n] = 1'b0;
                if (r_scr[n]) begin
                    r_a[n]  = 16'($urandom);
                    r_b[n]  = 16'($urandom);
                    r_c[n]  = 16'($urandom);
                    r_d[n]  = 16'($urandom);
                    r_op[n] = 8'($urandom);
                end
            end
        end
        drive();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((r_valid[0] || r_valid[1] || job || (cyc < free_at)) && (k < 600)) begin
            step();
            k++;
        end
        if (k >= 600) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles (cycle %0d)", k, cyc);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_compute"}, bus.calc_compute, 1'b0);
        chk({tag, "_resp0"}, bus.resp0_valid, 1'b0);
        chk({tag, "_resp1"}, bus.resp1_valid, 1'b0);
        chk({tag, "_illegal"}, bus.resp_illegal, 1'b0);
        chk({tag, "_ready"}, {bus.req0_ready, bus.req1_ready}, 2'b00);
        chk({tag, "_resp_regs"}, {bus.resp_data, bus.resp_im}, 32'h0);
        chk({tag, "_calc_regs"}, {bus.calc_a, bus.calc_b, bus.calc_c, bus.calc_d, bus.calc_opcode}, 72'h0);
    endtask

    task automatic model_reset();
        in_reset = 1;
        job      = 0;
        m_last   = 1;
        cm_cnt   = -1;
        took[0]  = 0;
        took[1]  = 0;
    endtask

    initial begin
        int r;
        logic [7:0] op;
        for (int n = 0; n < 2; n++) begin
            r_valid[n] = 1'b0;
            r_a[n] = '0; r_b[n] = '0; r_c[n] = '0; r_d[n] = '0; r_op[n] = '0;
            r_scr[n] = 0;
        end
        drive();
        bus.calc_out = '0;
        bus.calc_im  = '0;
        free_at = 0;
        cm_res  = '0;
        model_reset();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("por");
        repeat (3) step();
        rst_n    = 1'b1;
        in_reset = 0;
        free_at  = cyc;

        // Single add on req0.
        post(0, 16'd2, 16'd2, 16'd0, 16'd0, 8'd0, 0);
        drain();
        chk("single_add_data", bus.resp_data, 16'd4);

        // Reset in the middle of a long op.
        post(0, 16'd9, 16'd9, 16'd1, 16'd1, 8'd7, 0);
        repeat (40) step();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_wait");
        model_reset();
        repeat (2) step();
        rst_n    = 1'b1;
        in_reset = 0;
        free_at  = cyc;
        repeat (100) step();

        // Contention right after reset: req0 wins, then req1.
        post(0, 16'd10, 16'd3, 16'd0, 16'd0, 8'd1, 0);
        post(1, 16'd5, 16'd5, 16'd0, 16'd0, 8'd2, 0);
        drain();
        chk("contend_second_data", bus.resp_data, 16'd25);

        // Make req0 the last winner, then contend again: req1 first.
        post(0, 16'd1, 16'd1, 16'd0, 16'd0, 8'd0, 0);
        drain();
        post(0, 16'd10, 16'd3, 16'd0, 16'd0, 8'd1, 0);
        post(1, 16'd5, 16'd5, 16'd0, 16'd0, 8'd2, 0);
        drain();
        chk("contend_swap_data", bus.resp_data, 16'd7);

        // Long op then a shift waiting behind it.
        post(0, 16'd3, 16'd4, 16'd5, 16'd6, 8'd7, 0);
        repeat (3) step();
        post(1, 16'd128, 16'd2, 16'd0, 16'd0, 8'd8, 0);
        drain();
        chk("shift_data", bus.resp_data, 16'd512);

        // Illegal opcode on req1.
        post(1, 16'd1, 16'd2, 16'd3, 16'd4, 8'd12, 0);
        drain();
        chk("illegal_data", bus.resp_data, 16'd0);

        // Requester scrambles its fields immediately after accept.
        post(0, 16'd1000, 16'd7, 16'd3, 16'd2, 8'd6, 1);
        drain();
        chk("stable_div_data", bus.resp_data, 16'd142);

        // Random traffic.
        for (int it = 0; it < 50; it++) begin
            for (int n = 0; n < 2; n++) begin
                if (!r_valid[n] && ($urandom_range(0, 1) == 1)) begin
                    r = $urandom_range(0, 19);
                    if (r < 12)       op = 8'($urandom_range(0, 7)) + ((r % 2 == 0) ? 8'd0 : 8'd0);
                    else if (r < 14)  op = 8'd6;
                    else if (r == 14) op = 8'd7;
                    else              op = 8'($urandom_range(10, 255));
                    if (op == 8'd6 && r < 12) op = 8'd8;
                    if (op == 8'd7 && r < 12) op = 8'd9;
                    post(n, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), op,
                         ($urandom_range(0, 1) == 1));
                end
            end
            repeat ($urandom_range(1, 20)) step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
